// File: rtl/bnn_layer_scheduler.sv
// Binarized fully-connected layer sequencer: loads the input bit-vector byte
// by byte, streams weight bytes neuron-major from a synchronous ROM, forms
// XNOR-popcount scores per neuron and reports the argmax over valid/ready.
module bnn_layer_scheduler #(
  parameter int IN_BITS   = 64,
  parameter int N_NEURONS = 10,
  localparam int CHUNKS   = IN_BITS / 8,
  localparam int ACC_W    = $clog2(IN_BITS + 1),
  localparam int CLS_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
  localparam int AW       = ((N_NEURONS * CHUNKS) > 1) ? $clog2(N_NEURONS * CHUNKS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [AW-1:0]    w_addr,
  output logic             w_en,
  input  logic [7:0]       w_data,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CLS_W-1:0] result_class,
  output logic [ACC_W-1:0] result_score
);

  localparam int CW    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int TOTAL = N_NEURONS * CHUNKS;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, RESULT} state_t;

  state_t                state;
  logic [CW-1:0]         load_cnt;
  logic [IN_BITS-1:0]    in_vec;

  // Issue stage (p0): read-address counters
  logic [CW-1:0]         chunk_p0;
  logic [CLS_W-1:0]      neuron_p0;

  // Data stage (p1): tags aligned with w_data
  logic                  vld_p1;
  logic [CW-1:0]         chunk_p1;
  logic [CLS_W-1:0]      neuron_p1;
  logic [7:0]            in_byte_p1;
  logic [ACC_W-1:0]      score_p1;

  // Accumulate/argmax stage (p2)
  logic [ACC_W-1:0]      acc_p2;
  logic [ACC_W-1:0]      best_score;
  logic [CLS_W-1:0]      best_class;
  logic                  done_p2;

  logic                  in_fire;
  logic                  last_byte;

  function automatic logic [3:0] popcnt8(input logic [7:0] b);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, b[i]};
    return n;
  endfunction

  assign in_fire   = in_valid && in_ready;
  assign last_byte = (load_cnt == CW'(CHUNKS - 1));

  // Store each accepted byte at its slot of the input vector
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int k = 0; k < CHUNKS; k++) begin
        if (load_cnt == CW'(k)) in_vec[8*k +: 8] <= in_data;
      end
    end
  end

  // Select the input byte matching the chunk of the returning weight byte
  always_comb begin
    in_byte_p1 = in_vec[7:0];
    for (int k = 0; k < CHUNKS; k++) begin
      if (chunk_p1 == CW'(k)) in_byte_p1 = in_vec[8*k +: 8];
    end
  end

  // Running score including this chunk; a neuron's first chunk restarts from zero
  always_comb begin
    score_p1 = ((chunk_p1 == '0) ? '0 : acc_p2)
             + ACC_W'(popcnt8(~(w_data ^ in_byte_p1)));
  end

  // Control FSM with registered handshake, busy and address outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_class <= '0;
      result_score <= '0;
      load_cnt     <= '0;
      w_en         <= 1'b0;
      w_addr       <= '0;
      chunk_p0     <= '0;
      neuron_p0    <= '0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (in_fire) begin
            busy <= 1'b1;
            if (last_byte) begin
              state     <= COMPUTE;
              in_ready  <= 1'b0;
              load_cnt  <= '0;
              w_en      <= 1'b1;
              w_addr    <= '0;
              chunk_p0  <= '0;
              neuron_p0 <= '0;
            end else begin
              state    <= LOAD;
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (w_en) begin
            if (w_addr == AW'(TOTAL - 1)) begin
              w_en <= 1'b0;
            end else begin
              w_addr <= w_addr + 1'b1;
              if (chunk_p0 == CW'(CHUNKS - 1)) begin
                chunk_p0  <= '0;
                neuron_p0 <= neuron_p0 + 1'b1;
              end else begin
                chunk_p0 <= chunk_p0 + 1'b1;
              end
            end
          end
          if (done_p2) begin
            state        <= RESULT;
            busy         <= 1'b0;
            result_valid <= 1'b1;
            result_class <= best_class;
            result_score <= best_score;
          end
        end
        RESULT: begin
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            in_ready     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Score pipeline: tag each read, accumulate on return, track argmax
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      chunk_p1   <= '0;
      neuron_p1  <= '0;
      acc_p2     <= '0;
      best_score <= '0;
      best_class <= '0;
      done_p2    <= 1'b0;
    end else begin
      // p0 -> p1
      vld_p1    <= w_en;
      chunk_p1  <= chunk_p0;
      neuron_p1 <= neuron_p0;
      // p1 -> p2
      done_p2   <= 1'b0;
      if (vld_p1) begin
        acc_p2 <= score_p1;
        if (chunk_p1 == CW'(CHUNKS - 1)) begin
          if ((neuron_p1 == '0) || (score_p1 > best_score)) begin
            best_score <= score_p1;
            best_class <= neuron_p1;
          end
          if (neuron_p1 == CLS_W'(N_NEURONS - 1)) done_p2 <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bnn_layer_scheduler.sv
// Directed bench for bnn_layer_scheduler with a behavioural synchronous
// weight ROM and a table of hand-computed layer results.
module tb_bnn_layer_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] w_addr;
  logic       w_en;
  logic [7:0] w_data;
  logic       busy;
  logic       result_valid;
  logic       result_ready;
  logic [3:0] result_class;
  logic [6:0] result_score;

  bnn_layer_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .w_addr(w_addr), .w_en(w_en), .w_data(w_data),
    .busy(busy),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_class(result_class), .result_score(result_score)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rot;
    bit [7:0] in_b;
    bit [7:0] def_w;
    int       n_a;
    bit [7:0] w_a;
    int       n_b;
    bit [7:0] w_b;
    int       exp_cls;
    int       exp_score;
  } vec_t;

  vec_t       tbl [8];
  logic [7:0] rom [0:79];
  logic [7:0] vbytes [0:7];

  int compared = 0;
  int mismatched = 0;
  int pulses, exp_addr, addr_err;

  // Synchronous weight ROM; junk on cycles that do not follow a read
  always @(posedge clk) begin
    if (w_en) w_data <= rom[w_addr];
    else      w_data <= 8'($urandom_range(0, 255));
  end

  // Address-order monitor
  always @(negedge clk) begin
    if (rst_n && w_en) begin
      if (int'(w_addr) != exp_addr) addr_err++;
      exp_addr++;
      pulses++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit [7:0] rotl8(input bit [7:0] b, input int s);
    bit [15:0] d;
    d = {b, b} << (s % 8);
    return d[15:8];
  endfunction

  task automatic setup_case(input int i);
    bit [7:0] w;
    for (int n = 0; n < 10; n++) begin
      for (int c = 0; c < 8; c++) begin
        w = tbl[i].def_w;
        if (n == tbl[i].n_b) w = tbl[i].w_b;
        if (n == tbl[i].n_a) w = tbl[i].w_a;
        if (tbl[i].rot) w = rotl8(w, c);
        rom[n*8 + c] = w;
      end
    end
    for (int k = 0; k < 8; k++)
      vbytes[k] = tbl[i].rot ? rotl8(tbl[i].in_b, k) : tbl[i].in_b;
    pulses = 0; exp_addr = 0; addr_err = 0;
  endtask

  task automatic send_vec();
    int ir_err;
    ir_err = 0;
    for (int k = 0; k < 8; k++) begin
      in_data  = vbytes[k];
      in_valid = 1'b1;
      if (in_ready !== 1'b1) ir_err++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("in_ready_load", ir_err, 0);
  endtask

  // mode 0: result_ready tied high; 1: late handshake; 2: leave in RESULT
  task automatic run_case(input int i, input int mode);
    int lat, busy_err;
    setup_case(i);
    result_ready = (mode == 0);
    send_vec();
    lat = 0; busy_err = 0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (result_valid) break;
      if (busy !== 1'b1 || in_ready !== 1'b0) busy_err++;
      if (lat > 300) break;
    end
    chk($sformatf("latency_%0d", i), lat, 82);
    chk($sformatf("class_%0d", i), int'(result_class), tbl[i].exp_cls);
    chk($sformatf("score_%0d", i), int'(result_score), tbl[i].exp_score);
    chk($sformatf("w_en_pulses_%0d", i), pulses, 80);
    chk($sformatf("addr_order_%0d", i), addr_err, 0);
    chk($sformatf("busy_compute_%0d", i), busy_err, 0);
    chk($sformatf("busy_at_result_%0d", i), int'(busy), 0);
    if (mode == 0) begin
      @(posedge clk); #1;
      chk($sformatf("valid_one_cycle_%0d", i), int'(result_valid), 0);
      chk($sformatf("in_ready_after_%0d", i), int'(in_ready), 1);
    end else if (mode == 1) begin
      repeat (3) @(posedge clk);
      #1 result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
      chk($sformatf("valid_drop_%0d", i), int'(result_valid), 0);
    end
  endtask

  initial begin
    int bp_err, cap_cls, cap_score, guard;
    //          rot  in     def    n_a w_a    n_b w_b    cls score
    tbl[0] = '{1'b0, 8'hFF, 8'h00, 3, 8'hFF, 3, 8'hFF, 3, 64};
    tbl[1] = '{1'b0, 8'hA5, 8'hA5, 0, 8'hA5, 0, 8'hA5, 0, 64};
    tbl[2] = '{1'b0, 8'h0F, 8'hF0, 7, 8'h0F, 2, 8'h0E, 7, 64};
    tbl[3] = '{1'b0, 8'h00, 8'hFF, 9, 8'h00, 5, 8'h01, 9, 64};
    tbl[4] = '{1'b0, 8'h00, 8'hFF, 0, 8'hFF, 0, 8'hFF, 0, 0};
    tbl[5] = '{1'b0, 8'h00, 8'hFF, 6, 8'h03, 4, 8'h30, 4, 48};
    tbl[6] = '{1'b0, 8'h3C, 8'hC3, 9, 8'h3D, 1, 8'h38, 1, 56};
    tbl[7] = '{1'b1, 8'h01, 8'h02, 5, 8'h01, 5, 8'h01, 5, 64};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; result_ready = 1'b0;
    pulses = 0; exp_addr = 0; addr_err = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_w_en", int'(w_en), 0);
    chk("rst_w_addr", int'(w_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_result_class", int'(result_class), 0);
    chk("rst_result_score", int'(result_score), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_case(i, (i % 2 == 0) ? 0 : 1);

    // Backpressure: hold the result with in_valid asserted
    run_case(2, 2);
    cap_cls = int'(result_class); cap_score = int'(result_score);
    in_valid = 1'b1; in_data = 8'h77;
    bp_err = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (result_valid !== 1'b1 || int'(result_class) != cap_cls ||
          int'(result_score) != cap_score || in_ready !== 1'b0 || busy !== 1'b0)
        bp_err++;
    end
    chk("backpressure_hold", bp_err, 0);
    in_valid = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk("bp_valid_drop", int'(result_valid), 0);
    chk("bp_in_ready", int'(in_ready), 1);
    chk("bp_busy_idle", int'(busy), 0);
    chk("bp_class_retained", int'(result_class), 7);
    run_case(0, 0);

    // Reset in the middle of COMPUTE
    setup_case(3);
    result_ready = 1'b1;
    send_vec();
    guard = 0;
    while (!(w_en === 1'b1 && w_addr == 7'd40) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("reach_addr40", int'(w_addr), 40);
    rst_n = 1'b0;
    #1;
    chk("midrst_w_en", int'(w_en), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_result_valid", int'(result_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_class", int'(result_class), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_case(5, 1);
    run_case(7, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
